// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit: aligns/validates the ALU address, runs a
// req/ready handshake with a timeout, and reports completion or fault to the core.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ls_valid,
  input  logic        ls_write,
  input  logic [31:0] ls_addr,
  input  logic        ls_addr_ovf,
  input  logic [31:0] ls_wdata,
  output logic        ls_busy,
  output logic        ls_done,
  output logic        ls_fault,
  output logic [31:0] ls_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [7:0]  cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (ls_valid) begin
          we_q    <= ls_write;
          addr_q  <= {ls_addr[31:2], 2'b00};
          wdata_q <= ls_wdata;
          cnt     <= '0;
          // Bad addresses never reach the memory bus.
          state   <= (ls_addr[1:0] != 2'b00 || ls_addr_ovf) ? FAULT : REQ;
        end
        REQ: begin
          // A ready arriving in the last allowed cycle still completes normally.
          if (mem_ready) begin
            if (!we_q) rdata_q <= mem_rdata;
            state <= DONE;
          end else if (cnt == TO_LAST) begin
            state <= FAULT;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        FAULT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the registered state only, so reset drops them asynchronously.
  assign mem_req   = (state == REQ);
  assign mem_we    = (state == REQ) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ls_busy   = (state != IDLE);
  assign ls_done   = (state == DONE) || (state == FAULT);
  assign ls_fault  = (state == FAULT);
  assign ls_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: expected completions go into a scoreboard
// queue that an independent monitor pops on every ls_done pulse.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ls_valid, ls_write, ls_addr_ovf;
  logic [31:0] ls_addr, ls_wdata;
  logic        ls_busy, ls_done, ls_fault;
  logic [31:0] ls_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .ls_valid(ls_valid), .ls_write(ls_write), .ls_addr(ls_addr),
    .ls_addr_ovf(ls_addr_ovf), .ls_wdata(ls_wdata),
    .ls_busy(ls_busy), .ls_done(ls_done), .ls_fault(ls_fault), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fault;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_rdata = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every completion must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && ls_done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(ls_done), 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_fault", 32'(ls_fault), 32'(e.fault));
        chk("done_rdata", ls_rdata, e.rdata);
      end
    end
  end

  // Issue one access; req_cyc = cycles mem_req must be high, rdy_cyc = cycle
  // in which mem_ready is driven (0 = never), poke = re-assert ls_valid while busy.
  task automatic access(input logic wr, input logic [31:0] addr, input logic ovf,
                        input logic [31:0] wd, input int req_cyc, input int rdy_cyc,
                        input logic [31:0] rd, input logic exp_fault, input logic poke);
    exp_t e;
    @(negedge clk);
    ls_valid = 1'b1; ls_write = wr; ls_addr = addr; ls_addr_ovf = ovf; ls_wdata = wd;
    if (!exp_fault && !wr) last_rdata = rd;
    e.fault = exp_fault; e.rdata = last_rdata;
    sb.push_back(e);
    @(posedge clk); #1;
    ls_valid = 1'b0; ls_addr_ovf = 1'b0;
    for (int c = 1; c <= req_cyc + 1; c++) begin
      if (poke && c <= 2) begin ls_valid = 1'b1; ls_addr = 32'h200; end
      else ls_valid = 1'b0;
      mem_ready = (c == rdy_cyc);
      mem_rdata = (c == rdy_cyc) ? rd : (32'hBAD0_0000 | 32'(c));
      @(negedge clk);
      chk("mem_req", 32'(mem_req), 32'(c <= req_cyc));
      chk("busy", 32'(ls_busy), 32'h1);
      if (c <= req_cyc) begin
        chk("mem_addr", mem_addr, addr);
        chk("mem_we", 32'(mem_we), 32'(wr));
        if (wr) chk("mem_wdata", mem_wdata, wd);
      end
      @(posedge clk); #1;
      mem_ready = 1'b0;
    end
    ls_valid = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(ls_busy), 32'h0);
    chk("idle_req", 32'(mem_req), 32'h0);
  endtask

  initial begin
    reset_n = 1'b0; ls_valid = 1'b0; ls_write = 1'b0; ls_addr = '0;
    ls_addr_ovf = 1'b0; ls_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    #2;
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_busy", 32'(ls_busy), 32'h0);
    chk("rst_done", 32'(ls_done), 32'h0);
    chk("rst_fault", 32'(ls_fault), 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_rdata", ls_rdata, 32'h0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    // wr  addr          ovf   wdata          req rdy rdata          fault poke
    access(1'b0, 32'h100, 1'b0, 32'h0,        1,  1,  32'hDEADBEEF, 1'b0, 1'b0);
    access(1'b1, 32'h020, 1'b0, 32'h12345678, 4,  4,  32'hFFFF0000, 1'b0, 1'b0);
    access(1'b0, 32'h102, 1'b0, 32'h0,        0,  0,  32'h0,        1'b1, 1'b0);
    access(1'b0, 32'h100, 1'b1, 32'h0,        0,  0,  32'h0,        1'b1, 1'b0);
    access(1'b1, 32'h031, 1'b0, 32'hAAAA5555, 0,  0,  32'h0,        1'b1, 1'b0);
    access(1'b0, 32'h040, 1'b0, 32'h0,        4,  0,  32'h0,        1'b1, 1'b0);
    access(1'b0, 32'h044, 1'b0, 32'h0,        4,  4,  32'hCAFEF00D, 1'b0, 1'b0);
    access(1'b0, 32'h080, 1'b0, 32'h0,        3,  3,  32'h0BADF00D, 1'b0, 1'b1);
    access(1'b1, 32'h084, 1'b0, 32'h87654321, 4,  0,  32'h0,        1'b1, 1'b0);

    // Async reset in the middle of a request.
    @(negedge clk);
    ls_valid = 1'b1; ls_write = 1'b0; ls_addr = 32'h48;
    @(posedge clk); #1;
    ls_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_req", 32'(mem_req), 32'h1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("async_req", 32'(mem_req), 32'h0);
    chk("async_busy", 32'(ls_busy), 32'h0);
    chk("async_rdata", ls_rdata, 32'h0);
    chk("async_done", 32'(ls_done), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    last_rdata = 32'h0;

    access(1'b0, 32'h010, 1'b0, 32'h0,        2,  2,  32'h55AA55AA, 1'b0, 1'b0);
    access(1'b1, 32'h014, 1'b0, 32'h0F0F0F0F, 1,  1,  32'h0,        1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
